// File: rtl/echo_loader_pkg.sv
// Shared types for the echo loader bring-up core.
package echo_loader_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    FETCH,
    RECV,
    SEND,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/echo_loader_if.sv
// Bus interfaces towards instruction memory and the UART request queues.
interface IInstr;
  logic [31:0] addr;
  logic [31:0] instr;
  modport master (output addr, input instr);
  modport slave  (input addr, output instr);
endinterface

interface IRecvRequest;
  logic [31:0] size;
  logic [31:0] rd;
  logic        en;
  modport master (input size, input rd, output en);
  modport slave  (output size, output rd, input en);
endinterface

interface ISendRequest;
  logic        en;
  logic [31:0] content;
  logic        busy;
  modport master (output en, output content, input busy);
  modport slave  (input en, input content, output busy);
endinterface

// File: rtl/echo_loader_buf.sv
// Word buffer: one synchronous write port, one asynchronous read port.
module echo_loader_buf
  import echo_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned AW    = 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);

  // A zero-depth buffer still needs one slot to stay a legal array.
  localparam int unsigned SLOTS = (DEPTH == 0) ? 1 : DEPTH;
  localparam int unsigned BW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  word_t mem_q [SLOTS];

  always_ff @(posedge clk_i) begin
    if (we_i && (32'(waddr_i) < SLOTS)) begin
      mem_q[waddr_i[BW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = (32'(raddr_i) < SLOTS) ? mem_q[raddr_i[BW-1:0]] : '0;

endmodule

// File: rtl/echo_loader_core.sv
// Loads instruction-memory and UART-RX words into a buffer, then echoes them over UART-TX.
// Optional trailing checksum send: define ECHO_LOADER_CHECKSUM_EN.
module echo_loader_core
  import echo_loader_pkg::*;
#(
  parameter int unsigned INSTR_WORDS = 10,
  parameter int unsigned DATA_WORDS  = 10,
  parameter logic [31:0] INSTR_BASE  = 32'h0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         restart,
  IInstr.master        instr_mem,
  IRecvRequest.master  io_recv,
  ISendRequest.master  io_send,
  output logic         done
);

  localparam int unsigned TOTAL = INSTR_WORDS + DATA_WORDS;
  localparam int unsigned IW    = $clog2(TOTAL + 2);

  localparam logic [IW-1:0] ONE        = IW'(1);
  localparam logic [IW-1:0] INSTR_LAST = IW'(INSTR_WORDS);
  localparam logic [IW-1:0] DATA_LAST  = IW'(DATA_WORDS);
  localparam logic [IW-1:0] SEND_LAST  = IW'(TOTAL);
`ifdef ECHO_LOADER_CHECKSUM_EN
  localparam logic [IW-1:0] CSUM_LAST  = IW'(TOTAL + 1);
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          send_en_q, send_en_d;
  word_t         content_q, content_d;

  logic          buf_we;
  logic [IW-1:0] buf_waddr;
  word_t         buf_wdata;
  word_t         buf_rdata;

  logic          recv_pop;
  logic          send_issue;

  echo_loader_buf #(
    .DEPTH (TOTAL),
    .AW    (IW)
  ) u_buf (
    .clk_i   (clock),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (buf_wdata),
    .raddr_i (idx_q),
    .rdata_o (buf_rdata)
  );

  assign send_issue = (state_q == SEND) && !io_send.busy && !send_en_q
                      && (idx_q < SEND_LAST);

`ifdef ECHO_LOADER_CHECKSUM_EN
  word_t csum_q, csum_d;
  logic  csum_issue;

  // idx parks at TOTAL in CSUM, so the single checksum send moves it to TOTAL+1.
  assign csum_issue = (state_q == CSUM) && !io_send.busy && !send_en_q
                      && (idx_q == SEND_LAST);

  always_comb begin
    csum_d = csum_q;
    if (buf_we) begin
      csum_d = csum_q + buf_wdata;
    end
    if ((state_q == DONE) && restart) begin
      csum_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      idx_q     <= '0;
      send_en_q <= 1'b0;
      content_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      send_en_q <= send_en_d;
      content_q <= content_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: if (idx_q == INSTR_LAST) state_d = RECV;
      RECV:  if (idx_q == DATA_LAST) state_d = SEND;
      SEND: begin
        if ((idx_q == SEND_LAST) && !send_en_q) begin
`ifdef ECHO_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef ECHO_LOADER_CHECKSUM_EN
      CSUM:  if ((idx_q == CSUM_LAST) && !send_en_q) state_d = DONE;
`endif
      DONE:  if (restart) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    send_en_d = 1'b0;
    content_d = content_q;
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = instr_mem.instr;
    case (state_q)
      FETCH: begin
        // Read data lags addr by a cycle, so idx k captures the word fetched at k-1.
        if (idx_q != '0) begin
          buf_we    = 1'b1;
          buf_waddr = idx_q - ONE;
        end
        idx_d = (idx_q == INSTR_LAST) ? '0 : idx_q + ONE;
      end
      RECV: begin
        if (recv_pop) begin
          buf_we    = 1'b1;
          buf_waddr = INSTR_LAST + idx_q;
          buf_wdata = io_recv.rd;
          idx_d     = idx_q + ONE;
        end
        if (idx_q == DATA_LAST) begin
          idx_d = '0;
        end
      end
      SEND: begin
        if (send_issue) begin
          send_en_d = 1'b1;
          content_d = buf_rdata;
          idx_d     = idx_q + ONE;
        end
      end
`ifdef ECHO_LOADER_CHECKSUM_EN
      CSUM: begin
        if (csum_issue) begin
          send_en_d = 1'b1;
          content_d = csum_q;
          idx_d     = idx_q + ONE;
        end
      end
`endif
      DONE: begin
        if (restart) begin
          idx_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    instr_mem.addr = INSTR_BASE + 32'(idx_q);
    recv_pop       = (state_q == RECV) && (idx_q < DATA_LAST) && (io_recv.size != '0);
    done           = (state_q == DONE);
  end

  assign io_recv.en      = recv_pop;
  assign io_send.en      = send_en_q;
  assign io_send.content = content_q;

endmodule

// File: doc/echo_loader_core.md
# echo_loader_core

Parametrised bring-up core that replaces the fixed-size loopback core in the top level. It fetches a configurable run of words from instruction memory and then a configurable number of words from the UART receive queue into an internal buffer. It then transmits the whole buffer back over UART, optionally followed by a checksum word. After finishing it idles, and a `restart` pulse repeats the sequence; this lets the host check the instruction-memory, UART-RX and UART-TX paths end to end.

## Interface
- `INSTR_WORDS`, default 10: number of instruction-memory words fetched; range 0..1024.
- `DATA_WORDS`, default 10: number of UART-RX words captured; range 0..1024.
- `INSTR_BASE`, default 32'h0: first instruction-memory address fetched.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `restart`  in  1: one-cycle pulse; only honoured in DONE.
- `instr_mem`  IInstr.master  –: `addr` (32, out) and `instr` (32, in); read data is valid one cycle after `addr`.
- `io_recv`  IRecvRequest.master  –: `size` (32, in) is the queue occupancy; `rd` (32, in) is the head word, show-ahead; `en` (1, out) pops the head.
- `io_send`  ISendRequest.master  –: `en` (1, out) is the send pulse; `content` (32, out) is the word; `busy` (1, in) is the transmitter busy flag.
- `done`  out  1: high while in DONE.

## Operation
- `TOTAL = INSTR_WORDS + DATA_WORDS`. The buffer holds `TOTAL` 32-bit words. The index counter `idx` is `$clog2(TOTAL+2)` bits wide.
- States are FETCH → RECV → SEND → (CSUM) → DONE. After reset the core enters FETCH.
- FETCH:
  - `instr_mem.addr = INSTR_BASE + idx`, 32-bit modulo add, combinational.
  - On each cycle with 0 < `idx` ≤ `INSTR_WORDS`, write `buf[idx-1] <= instr`.
  - When `idx == INSTR_WORDS`, clear `idx` and go to RECV.
  - `INSTR_WORDS = 0` gives one FETCH cycle and no buffer writes.
- RECV:
  - `io_recv.en = (state==RECV) && (idx < DATA_WORDS) && (size != 0)`, combinational.
  - When `en` is high: `buf[INSTR_WORDS+idx] <= rd` and `idx++`.
  - When `size == 0`, wait indefinitely; `en` stays low.
  - When `idx == DATA_WORDS`, clear `idx` and go to SEND. `en` never pops beyond `DATA_WORDS`.
- SEND:
  - Issue condition: `!busy && !io_send.en && idx < TOTAL`.
  - On issue, register `io_send.en <= 1`, `content <= buf[idx]`, and `idx++`.
  - `io_send.en` is a one-cycle pulse and is cleared on the following cycle unconditionally.
  - Consecutive issues are therefore at least 2 cycles apart.
  - Once `idx == TOTAL` and `io_send.en` is low, go to CSUM if the feature is enabled, otherwise to DONE.
- DONE: `done=1`. On `restart`, clear `idx`, clear the checksum, and go to FETCH. `restart` in any other state is ignored.
- Buffer contents are not cleared by reset or restart. They are overwritten on each pass.

## Timing
- Reset values: `state=FETCH`, `idx=0`, `io_send.en=0`, `io_send.content=0`, `done=0`, checksum 0.
- Combinational outputs during reset: `instr_mem.addr=INSTR_BASE`, `io_recv.en=0`.
- FETCH takes exactly `INSTR_WORDS+1` cycles.
- RECV takes at least `DATA_WORDS` cycles: one cycle per word when `size` stays nonzero.
- First `io_send.en` is asserted 1 cycle after entering SEND, provided `busy=0`.
- Handshake assumption: the transmitter raises `busy` no later than the cycle after it sees `en`.
- Reset asserted mid-operation aborts immediately: any in-flight `io_send.en` drops asynchronously and no further pops occur.
- With `TOTAL = 0` the core passes through SEND without issuing and reaches DONE.

## Configuration
- `ECHO_LOADER_CHECKSUM_EN` defined:
  - A 32-bit checksum accumulates the modulo-2^32 sum of every word written to the buffer.
  - CSUM issues one extra send with `content = checksum`, under the same issue rule as SEND, then goes to DONE.
  - The checksum resets to 0 on reset and on restart.
- `ECHO_LOADER_CHECKSUM_EN` undefined: no CSUM state, no accumulator logic, and exactly `TOTAL` words are sent.

## Structure
- Package `echo_loader_pkg` contains `word_t` (`logic [31:0]`) and the `state_t` enum: FETCH, RECV, SEND, CSUM, DONE. CSUM is always declared, even when the feature is compiled out.
- Sub-module `echo_loader_buf`: `TOTAL`-deep register file with one synchronous write port and one asynchronous read port. Depth is parameterised; it handles `TOTAL=0` by holding a 1-entry dummy.

## Test plan
- Defaults; imem[i]=32'hA000_0000+i; RX queue preloaded with 32'hB0+j, j=0..9, `busy` tied 0 → 20 sends: A0000000..A0000009 then B0..B9. Sends are spaced exactly 2 cycles apart. `done` rises after the last send.
- RX starved: size=0 for 50 cycles after FETCH, then words arrive one at a time → `io_recv.en` stays 0 while empty. There are no extra pops, and the final send order is unchanged.
- `busy` held high for 7 cycles after every `en` → each next `en` occurs 1 cycle after `busy` falls, and no word is dropped or duplicated.
- `INSTR_WORDS=0`, `DATA_WORDS=3`, `INSTR_BASE=32'h100`, RX 1,2,3 → sends 1,2,3 only. With `ECHO_LOADER_CHECKSUM_EN` defined, a 4th send of 6 follows.
- `reset_n` pulled low during the 5th send → `io_send.en`=0 immediately. After release, FETCH restarts at `addr`=`INSTR_BASE`.
- In DONE, pulse `restart` with new imem contents → the second pass sends the new words. A `restart` pulsed during SEND is ignored.
